// File: rtl/neopixel_pkg.sv
// Shared NeoPixel types and widths for the transmit and receive paths.
package neopixel_pkg;

  localparam int CounterWidth = 16;
  localparam int WordBits     = 24;

  typedef struct packed {
    logic [CounterWidth-1:0] t_thresh;
    logic [CounterWidth-1:0] t_max_high;
    logic [CounterWidth-1:0] t_latch;
  } rx_cfg_t;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    HIGH,
    LOW,
    ERROR
  } rx_state_t;

endpackage

// File: rtl/neopixel_receiver.sv
// WS2812 single-wire receiver: measures high/low pulse widths, rebuilds 24-bit GRB
// words and pushes them to a FIFO, with frame (latch) and error reporting.
module neopixel_receiver
  import neopixel_pkg::*;
#(
  parameter int SyncStages  = 2,
  parameter int PixCntWidth = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   data_i,
  input  rx_cfg_t                cfg_i,
  input  logic                   fifo_full_i,
  output logic [WordBits-1:0]    fifo_data_o,
  output logic                   fifo_push_o,
  output logic                   frame_done_o,
  output logic [PixCntWidth-1:0] pix_count_o,
  output logic                   overflow_o,
  output logic                   frame_err_o
);

  logic [SyncStages-1:0]  sync_reg;
  logic                   data_s;
  logic                   data_d_reg;
  logic                   rise;
  logic                   fall;
  logic                   edge_det;

  rx_state_t              state_reg, state_next;
  logic [CounterWidth-1:0] count_reg;
  logic [CounterWidth:0]  count_p1;
  logic [4:0]             bit_idx_reg;
  logic [WordBits-1:0]    shift_reg;
  logic [WordBits-1:0]    shift_next;
  logic [WordBits-1:0]    word_reg;
  logic                   word_valid_reg;
  logic [PixCntWidth-1:0] pix_cnt_reg;
  logic [PixCntWidth-1:0] pix_count_reg;
  logic                   frame_done_reg;
  logic                   frame_err_reg;

  logic                   bit_val;
  logic                   bit_done;
  logic                   latch;
  logic                   max_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_reg   <= '0;
      data_d_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SyncStages-2:0], data_i};
      data_d_reg <= data_s;
    end
  end

  assign data_s   = sync_reg[SyncStages-1];
  assign rise     = data_s & ~data_d_reg;
  assign fall     = ~data_s & data_d_reg;
  assign edge_det = rise | fall;

  // count_p1 is the elapsed width in cycles; the extra bit keeps zero thresholds from wrapping
  assign count_p1   = {1'b0, count_reg} + {{CounterWidth{1'b0}}, 1'b1};
  assign bit_val    = (count_p1 >= {1'b0, cfg_i.t_thresh});
  assign shift_next = {shift_reg[WordBits-2:0], bit_val};

  always_comb begin
    state_next = state_reg;
    bit_done   = 1'b0;
    latch      = 1'b0;
    max_err    = 1'b0;
    case (state_reg)
      ARM: begin
        if ((cfg_i.t_latch != '0) && !data_s && !edge_det &&
            (count_p1 >= {1'b0, cfg_i.t_latch})) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (rise) state_next = HIGH;
      end
      HIGH: begin
        if (count_reg >= cfg_i.t_max_high) begin
          max_err    = 1'b1;
          state_next = ERROR;
        end else if (fall) begin
          bit_done   = 1'b1;
          state_next = LOW;
        end
      end
      LOW: begin
        // a rise landing exactly on the latch cycle starts the next frame directly
        if (count_p1 == {1'b0, cfg_i.t_latch}) begin
          latch      = 1'b1;
          state_next = rise ? HIGH : IDLE;
        end else if (rise) begin
          state_next = HIGH;
        end
      end
      ERROR:   state_next = ARM;
      default: state_next = ARM;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ARM;
      count_reg      <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      pix_cnt_reg    <= '0;
      pix_count_reg  <= '0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (edge_det) begin
        count_reg <= '0;
      end else if ((state_reg inside {HIGH, LOW, ARM}) && (count_reg != '1)) begin
        count_reg <= count_reg + CounterWidth'(1);
      end

      word_valid_reg <= bit_done && (bit_idx_reg == 5'd23);
      if (state_reg inside {ARM, ERROR} || latch) begin
        bit_idx_reg <= '0;
        shift_reg   <= '0;
        pix_cnt_reg <= '0;
      end else if (bit_done) begin
        shift_reg <= shift_next;
        if (bit_idx_reg == 5'd23) begin
          bit_idx_reg <= '0;
          word_reg    <= shift_next;
          if (pix_cnt_reg != '1) pix_cnt_reg <= pix_cnt_reg + PixCntWidth'(1);
        end else begin
          bit_idx_reg <= bit_idx_reg + 5'd1;
        end
      end

      frame_done_reg <= latch;
      frame_err_reg  <= (latch && (bit_idx_reg != '0)) || max_err;
      if (latch) pix_count_reg <= pix_cnt_reg;
    end
  end

  assign fifo_data_o  = word_reg;
  assign fifo_push_o  = word_valid_reg & ~fifo_full_i;
  assign overflow_o   = word_valid_reg & fifo_full_i;
  assign frame_done_o = frame_done_reg;
  assign frame_err_o  = frame_err_reg;
  assign pix_count_o  = pix_count_reg;

endmodule

// File: tb/tb_neopixel_receiver.sv
// Directed-plus-random bench for neopixel_receiver; frame-level expectations come
// from the pixels the bench chose to send.
`timescale 1ns/1ps
module tb_neopixel_receiver;
  import neopixel_pkg::*;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          data_i = 1'b0;
  rx_cfg_t       cfg_i;
  logic          fifo_full_i = 1'b0;
  logic [23:0]   fifo_data_o;
  logic          fifo_push_o;
  logic          frame_done_o;
  logic [9:0]    pix_count_o;
  logic          overflow_o;
  logic          frame_err_o;

  int total = 0;
  int bad = 0;

  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];
  int ovf_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int last_pix = 0;
  int p0, d0, e0, o0, b0;

  neopixel_receiver dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .data_i      (data_i),
    .cfg_i       (cfg_i),
    .fifo_full_i (fifo_full_i),
    .fifo_data_o (fifo_data_o),
    .fifo_push_o (fifo_push_o),
    .frame_done_o(frame_done_o),
    .pix_count_o (pix_count_o),
    .overflow_o  (overflow_o),
    .frame_err_o (frame_err_o)
  );

  always #25 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_push_o) got_q.push_back(fifo_data_o);
    if (overflow_o) ovf_cnt++;
    if (frame_done_o) begin
      done_cnt++;
      last_pix = int'(pix_count_o);
    end
    if (frame_err_o) err_cnt++;
    if (frame_done_o && frame_err_o) both_cnt++;
  end

  initial begin
    #4500000;
    $display("FAIL timeout: run did not complete (obs=running exp=finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
    $display("check %-18s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input int n);
    data_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  task automatic send_pixel_rand(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) begin
      if (p[i]) send_bit(1'b1, int'($urandom_range(24, 12)), int'($urandom_range(20, 5)));
      else      send_bit(1'b0, int'($urandom_range(11, 3)), int'($urandom_range(20, 5)));
    end
  endtask

  task automatic snap();
    p0 = got_q.size(); d0 = done_cnt; e0 = err_cnt; o0 = ovf_cnt; b0 = both_cnt;
  endtask

  // compares the words and pulses seen since snap() against the bench's expectations
  task automatic check_window(input string tag, input int exp_done, input int exp_err,
                              input int exp_ovf, input int exp_pix);
    int n;
    n = got_q.size() - p0;
    check({tag, ".pushes"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check({tag, ".word"}, got_q[p0+i], exp_q[i]);
    check({tag, ".done"}, done_cnt - d0, exp_done);
    check({tag, ".err"}, err_cnt - e0, exp_err);
    check({tag, ".ovf"}, ovf_cnt - o0, exp_ovf);
    if (exp_done > 0) check({tag, ".pix"}, last_pix, exp_pix);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".push"}, fifo_push_o, 0);
    check({tag, ".done"}, frame_done_o, 0);
    check({tag, ".pix"}, pix_count_o, 0);
    check({tag, ".ovf"}, overflow_o, 0);
    check({tag, ".err"}, frame_err_o, 0);
    check({tag, ".data"}, fifo_data_o, 0);
  endtask

  initial begin
    logic [23:0] pix;
    logic [23:0] px[3];
    int npix;

    cfg_i.t_thresh   = 16'd12;
    cfg_i.t_max_high = 16'd40;
    cfg_i.t_latch    = 16'd1000;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_ni = 1'b1;
    drive(1'b0, 1020);

    // known pixel with nominal WS2812 timings
    snap();
    pix = 24'hA50F81;
    for (int i = 23; i >= 0; i--) begin
      if (pix[i]) send_bit(1'b1, 16, 9);
      else        send_bit(1'b0, 8, 17);
    end
    exp_q.push_back(24'hA50F81);
    drive(1'b0, 1020);
    check_window("known", 1, 0, 0, 1);

    // three pixels, fifo full during the second word
    snap();
    for (int k = 0; k < 3; k++) px[k] = 24'($urandom);
    for (int k = 0; k < 3; k++) begin
      fifo_full_i = (k == 1);
      send_pixel_rand(px[k]);
    end
    fifo_full_i = 1'b0;
    exp_q.push_back(px[0]);
    exp_q.push_back(px[2]);
    drive(1'b0, 1020);
    check_window("full", 1, 0, 1, 3);

    // ten bits then latch: partial word
    snap();
    pix = 24'($urandom);
    for (int i = 23; i >= 14; i--)
      send_bit(pix[i], pix[i] ? 16 : 6, 10);
    drive(1'b0, 1020);
    check_window("partial", 1, 1, 0, 0);
    check("partial.same_cycle", both_cnt - b0, 1);

    // random frames
    for (int f = 0; f < 3; f++) begin
      snap();
      npix = int'($urandom_range(3, 1));
      for (int k = 0; k < npix; k++) begin
        pix = 24'($urandom);
        send_pixel_rand(pix);
        exp_q.push_back(pix);
      end
      drive(1'b0, 1020);
      check_window("random", 1, 0, 0, npix);
    end

    // overlong high mid-word, garbage while re-arming, then a clean frame
    snap();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 14, 8);
    drive(1'b1, 41);
    drive(1'b0, 20);
    send_pixel_rand(24'($urandom));
    drive(1'b0, 1020);
    pix = 24'($urandom);
    send_pixel_rand(pix);
    exp_q.push_back(pix);
    drive(1'b0, 1020);
    check_window("maxhigh", 1, 1, 0, 1);

    // boundary widths: 11 -> 0, 12 -> 1, 999 low inside the frame is not a latch
    snap();
    pix = 24'($urandom);
    for (int i = 23; i >= 0; i--)
      send_bit(pix[i], pix[i] ? 12 : 11, (i == 16) ? 999 : 6);
    exp_q.push_back(pix);
    drive(1'b0, 1020);
    check_window("boundary", 1, 0, 0, 1);

    // 40-cycle high is still legal
    snap();
    pix = 24'($urandom);
    for (int i = 23; i >= 0; i--)
      send_bit(pix[i], pix[i] ? 40 : 5, 7);
    exp_q.push_back(pix);
    drive(1'b0, 1020);
    check_window("high40", 1, 0, 0, 1);

    // reset after bit 5 of a frame
    snap();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 15, 8);
    send_bit(1'b0, 5, 3);
    rst_ni = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    rst_ni = 1'b1;
    drive(1'b0, 1020);
    check("midreset.nopush", got_q.size() - p0, 0);
    snap();
    pix = 24'($urandom);
    send_pixel_rand(pix);
    exp_q.push_back(pix);
    drive(1'b0, 1020);
    check_window("after_reset", 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
